hero_write_arb: RTL and testbench
=================================

# hero_write_arb

Parametrised N-channel arbiter and buffer for hero write traffic. Each channel delivers hero writes as multi-beat transactions: zero or more VALID beats followed by one DONE beat. Each channel buffers its beats in a private FIFO. The block merges the channels onto one hero output bus using round-robin arbitration at transaction granularity, so a transaction is never interleaved with another. It sits between several hero write producers and the single hero bus around the bag, and adds backpressure in both directions, which the single-producer bus lacks.

## Interface
- NUM_CH, 4: number of input channels, 2..8.
- DATA_W, HERO_WIDTH (36): hero wdat width.
- FIFO_DEPTH, 4: beats per channel FIFO; power of two, 2..16.
- clk  in  1  block clock.
- rst  in  1  reset; synchronous, active-high.
- in_cycle_type  in  NUM_CH*4  per-channel CYCLE_TYPE; channel c occupies bits [4c+3:4c].
- in_wdat  in  NUM_CH*DATA_W  per-channel write data.
- in_clk_en  in  NUM_CH  per-channel clock enable field.
- in_ready  out  NUM_CH  channel c can accept a beat (its FIFO is not full).
- out_cycle_type  out  4  merged CYCLE_TYPE.
- out_wdat  out  DATA_W  merged write data.
- out_clk_en  out  1  merged clock enable field.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_grant  out  $clog2(NUM_CH)  channel currently driving the output.
- err_illegal  out  1  sticky flag: an illegal cycle_type encoding was seen on an input.
- txn_count  out  16  count of completed output transactions; wraps.

## Operation
- Input beat accepted on channel c when in_cycle_type[c] ∈ {VALID, DONE} and in_ready[c]=1. The beat, its DATA_W data and its clk_en are pushed into FIFO c.
- IDLE beats are never stored.
- Encodings other than IDLE=0, VALID=1, DONE=2 are treated as IDLE, not stored, and set err_illegal.
- A lone DONE beat is a legal single-beat transaction.
- Arbiter states:
  - UNLOCKED: pick the first non-empty FIFO at or after rr_ptr, searching cyclically. Grant it and go to LOCKED in the same cycle; the head beat is presented that cycle.
  - LOCKED: output comes only from the granted FIFO. Return to UNLOCKED when a DONE beat transfers, i.e. out_cycle_type=DONE and out_ready=1. At that point rr_ptr = grant+1 mod NUM_CH and txn_count increments.
- If the granted FIFO is empty mid-transaction, the output shows IDLE (a bubble) and the lock is held. Other channels keep buffering but are not served.
- Output hold rule: while out_cycle_type≠IDLE and out_ready=0, out_cycle_type, out_wdat, out_clk_en and out_grant stay stable. The FIFO pops only on an output transfer.
- Simultaneous push and pop on a full FIFO: the pop frees space but in_ready does not see it this cycle. in_ready is registered from FIFO occupancy, so in_ready=0 and no push occurs.
- Simultaneous push and pop on an empty FIFO cannot happen: the head appears only the cycle after the push.
- txn_count wraps from 0xFFFF to 0.

## Timing
- Reset values:
  - in_ready all ones.
  - out_cycle_type IDLE; out_wdat 0; out_clk_en 0; out_grant 0.
  - err_illegal 0; txn_count 0; rr_ptr 0; state UNLOCKED; all FIFOs empty.
- Latency: a beat accepted in cycle N is visible on the output at N+1 at the earliest.
- Output fields are driven combinationally from the FIFO head register and the grant state. There is no combinational path from out_ready to the outputs beyond the pop.
- Throughput: one beat per cycle sustained.
- A new grant is possible in the cycle after a DONE transfer.
- Reset mid-transaction: all FIFOs are flushed, partial transactions are discarded, and the outputs return to their reset values the following cycle.

## Structure
- The shared hero package holds the following:
  - CYCLE_TYPE enum with IDLE=0, VALID=1, DONE=2.
  - HERO_WIDTH.
  - New constant HERO_ARB_MAX_CH=8.
  - New typedef hero_beat_t {CYCLE_TYPE cycle_type; logic [DATA_W-1:0] wdat; logic clk_en}, used as the FIFO entry type.
- Sub-module hero_fifo: a synchronous FIFO with registered full/empty, parametrised by width and depth, instantiated NUM_CH times.
- Arbiter FSM, rr_ptr, counter and error flag live in the top level.

## Test plan
- Single channel, ch0 sends VALID,VALID,DONE with wdat 0x1,0x2,0x3, out_ready=1 → same three beats on outputs at cycles N+1..N+3, out_grant=0, txn_count=1.
- All 4 channels each send a 2-beat transaction in the same cycle → outputs are ch0, ch1, ch2, ch3 in order with no interleaving; txn_count=4; rr_ptr returns to 0.
- ch1 locked, VALID sent, then a 3-cycle input gap before DONE, while ch2 has data waiting → 3 IDLE output cycles, out_grant stays 1, ch2 served only after ch1's DONE.
- out_ready held 0 for 5 cycles mid-transaction with FIFO_DEPTH=4 and the producer streaming → outputs stable throughout; in_ready drops after 4 pushes; no beat lost or duplicated.
- in_cycle_type=0xF on ch3 → err_illegal=1 and stays set; nothing enqueued; the other channels are unaffected.
- rst pulsed while ch0 is mid-transaction with 2 beats buffered → next cycle outputs IDLE, in_ready all ones, txn_count=0; a fresh transaction then completes normally.

Source files
------------

// File: rtl/hero_write_arb_pkg.sv
// Shared hero bus types and constants for the write arbiter.
package hero_write_arb_pkg;

  localparam int HERO_WIDTH      = 36;
  localparam int HERO_ARB_MAX_CH = 8;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    VALID = 4'd1,
    DONE  = 4'd2
  } cycle_type_e;

  typedef struct packed {
    cycle_type_e             cycle_type;
    logic [HERO_WIDTH-1:0]   wdat;
    logic                    clk_en;
  } hero_beat_t;

  function automatic logic is_beat(input logic [3:0] ct);
    return (ct == 4'd1) || (ct == 4'd2);
  endfunction

  function automatic logic is_illegal(input logic [3:0] ct);
    return ct > 4'd2;
  endfunction

endpackage

// File: rtl/hero_write_arb_if.sv
// Producer-side and hero-bus-side signals of the write arbiter.
interface hero_write_arb_if
  import hero_write_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = HERO_WIDTH
);
  localparam int GW = $clog2(NUM_CH);

  logic [NUM_CH*4-1:0]      in_cycle_type;
  logic [NUM_CH*DATA_W-1:0] in_wdat;
  logic [NUM_CH-1:0]        in_clk_en;
  logic [NUM_CH-1:0]        in_ready;
  cycle_type_e              out_cycle_type;
  logic [DATA_W-1:0]        out_wdat;
  logic                     out_clk_en;
  logic                     out_ready;
  logic [GW-1:0]            out_grant;
  logic                     err_illegal;
  logic [15:0]              txn_count;

  modport slave (
    input  in_cycle_type, in_wdat, in_clk_en, out_ready,
    output in_ready, out_cycle_type, out_wdat, out_clk_en, out_grant, err_illegal, txn_count
  );

  modport master (
    output in_cycle_type, in_wdat, in_clk_en, out_ready,
    input  in_ready, out_cycle_type, out_wdat, out_clk_en, out_grant, err_illegal, txn_count
  );

endinterface

// File: rtl/hero_write_arb_fifo.sv
// Synchronous FIFO with registered full/empty; head word is read combinationally from storage.
// A pushed word becomes visible at the head one cycle later.
module hero_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdat_i,
  output logic [WIDTH-1:0] rdat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;

  always_comb cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdat_i;
  end

  assign rdat_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/hero_write_arb.sv
// Merges NUM_CH buffered hero write channels onto one hero bus, round-robin per transaction.
// A granted channel owns the bus until its DONE beat transfers; an empty owner shows IDLE bubbles.
module hero_write_arb
  import hero_write_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = HERO_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  hero_write_arb_if.slave bus
);
  localparam int GW = $clog2(NUM_CH);

  // Same layout as hero_beat_t, sized by this instance's DATA_W.
  typedef struct packed {
    cycle_type_e       cycle_type;
    logic [DATA_W-1:0] wdat;
    logic              clk_en;
  } beat_t;
  localparam int BEAT_W = $bits(beat_t);

  typedef enum logic {UNLOCKED, LOCKED} arb_state_e;

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick, cur;
  logic              pick_vld, cur_vld, fire;
  logic [15:0]       txn_q, txn_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] push, pop, full, empty, illegal;
  beat_t             wr_beat [NUM_CH];
  beat_t             rd_beat [NUM_CH];
  beat_t             head;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [3:0] ct;
    assign ct         = bus.in_cycle_type[4*c +: 4];
    assign push[c]    = is_beat(ct) && !full[c];
    assign illegal[c] = is_illegal(ct);
    assign wr_beat[c] = '{cycle_type: cycle_type_e'(ct),
                          wdat:       bus.in_wdat[DATA_W*c +: DATA_W],
                          clk_en:     bus.in_clk_en[c]};

    hero_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push[c]),
      .pop_i  (pop[c]),
      .wdat_i (wr_beat[c]),
      .rdat_o (rd_beat[c]),
      .full_o (full[c]),
      .empty_o(empty[c])
    );
  end

  assign bus.in_ready = ~full;

  // Scan downwards so the first non-empty channel at or after rr_ptr wins.
  always_comb begin
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!empty[(int'(rr_ptr_q) + i) % NUM_CH]) begin
        pick     = GW'((int'(rr_ptr_q) + i) % NUM_CH);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    txn_d    = txn_q;
    err_d    = err_q | (|illegal);
    cur      = grant_q;
    cur_vld  = 1'b0;
    pop      = '0;
    case (state_q)
      UNLOCKED: begin
        if (pick_vld) begin
          cur     = pick;
          cur_vld = 1'b1;
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED:  cur_vld = !empty[grant_q];
      default: ;
    endcase
    head     = rd_beat[cur];
    fire     = cur_vld && bus.out_ready;
    pop[cur] = fire;
    if (fire && head.cycle_type == DONE) begin
      state_d  = UNLOCKED;
      rr_ptr_d = (cur == GW'(NUM_CH - 1)) ? '0 : cur + 1'b1;
      txn_d    = txn_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      txn_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      txn_q    <= txn_d;
      err_q    <= err_d;
    end
  end

  assign bus.out_cycle_type = cur_vld ? head.cycle_type : IDLE;
  assign bus.out_wdat       = cur_vld ? head.wdat : '0;
  assign bus.out_clk_en     = cur_vld && head.clk_en;
  assign bus.out_grant      = cur;
  assign bus.err_illegal    = err_q;
  assign bus.txn_count      = txn_q;

endmodule

// File: tb/tb_hero_write_arb.sv
// Directed bench for hero_write_arb: 4 channels, 36-bit data, 4-deep FIFOs.
module tb_hero_write_arb;
  import hero_write_arb_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = HERO_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hero_write_arb_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

  hero_write_arb #(.NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input logic [3:0] ct, input logic [35:0] d,
                                           input logic ce, input logic [1:0] g);
    return {21'd0, ct, d, ce, g};
  endfunction

  function automatic logic [63:0] out_beat();
    return {21'd0, 4'(bus.out_cycle_type), bus.out_wdat, bus.out_clk_en, bus.out_grant};
  endfunction

  task automatic drive(input int c, input logic [3:0] ct, input logic [DW-1:0] d, input logic ce);
    bus.in_cycle_type[4*c +: 4] = ct;
    bus.in_wdat[DW*c +: DW]     = d;
    bus.in_clk_en[c]            = ce;
  endtask

  task automatic idle_all();
    bus.in_cycle_type = '0;
    bus.in_wdat       = '0;
    bus.in_clk_en     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] got[$];
  int          p;
  logic        acc;
  logic        drop_seen;
  int          pushes_at_drop;

  initial begin
    idle_all();
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_in_ready", 64'(bus.in_ready), 64'hF);
    chk("rst_out", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd0));
    chk("rst_err", 64'(bus.err_illegal), 64'd0);
    chk("rst_txn", 64'(bus.txn_count), 64'd0);

    // Single channel: V1, V2, D3 on ch0
    drive(0, 4'd1, 36'h1, 1'b0); tick();
    chk("t1_b0", out_beat(), exp_beat(4'd1, 36'h1, 1'b0, 2'd0));
    drive(0, 4'd1, 36'h2, 1'b1); tick();
    chk("t1_b1", out_beat(), exp_beat(4'd1, 36'h2, 1'b1, 2'd0));
    drive(0, 4'd2, 36'h3, 1'b0); tick();
    chk("t1_b2", out_beat(), exp_beat(4'd2, 36'h3, 1'b0, 2'd0));
    idle_all(); tick();
    chk("t1_idle", 64'(bus.out_cycle_type), 64'd0);
    chk("t1_txn", 64'(bus.txn_count), 64'd1);

    // Restart from rr_ptr=0, then all four channels send a 2-beat transaction together
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < NCH; c++) drive(c, 4'd1, 36'h10 + 36'(c), 1'b0);
    tick();
    chk("t2_b0", out_beat(), exp_beat(4'd1, 36'h10, 1'b0, 2'd0));
    for (int c = 0; c < NCH; c++) drive(c, 4'd2, 36'h20 + 36'(c), 1'b1);
    tick();
    chk("t2_b1", out_beat(), exp_beat(4'd2, 36'h20, 1'b1, 2'd0));
    idle_all();
    for (int k = 2; k < 8; k++) begin
      tick();
      chk($sformatf("t2_b%0d", k), out_beat(),
          exp_beat((k % 2) ? 4'd2 : 4'd1, ((k % 2) ? 36'h20 : 36'h10) + 36'(k / 2),
                   1'((k % 2)), 2'(k / 2)));
    end
    tick();
    chk("t2_idle", 64'(bus.out_cycle_type), 64'd0);
    chk("t2_txn", 64'(bus.txn_count), 64'd4);
    chk("t2_rr", 64'(dut.rr_ptr_q), 64'd0);

    // ch1 locked with a 3-cycle gap while ch2 waits
    drive(1, 4'd1, 36'h31, 1'b0); tick();
    chk("t3_v31", out_beat(), exp_beat(4'd1, 36'h31, 1'b0, 2'd1));
    drive(1, 4'd0, 36'h0, 1'b0); drive(2, 4'd1, 36'h41, 1'b0); tick();
    chk("t3_gap0", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd1));
    drive(2, 4'd2, 36'h42, 1'b0); tick();
    chk("t3_gap1", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd1));
    idle_all(); tick();
    chk("t3_gap2", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd1));
    drive(1, 4'd2, 36'h32, 1'b0); tick();
    chk("t3_d32", out_beat(), exp_beat(4'd2, 36'h32, 1'b0, 2'd1));
    idle_all(); tick();
    chk("t3_v41", out_beat(), exp_beat(4'd1, 36'h41, 1'b0, 2'd2));
    tick();
    chk("t3_d42", out_beat(), exp_beat(4'd2, 36'h42, 1'b0, 2'd2));
    tick();
    chk("t3_idle", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd2));
    chk("t3_txn", 64'(bus.txn_count), 64'd6);

    // out_ready low for 5 cycles while ch0 streams V50..V54, D55
    p = 0;
    drop_seen = 1'b0;
    pushes_at_drop = -1;
    for (int k = 0; k < 14; k++) begin
      bus.out_ready = (k >= 1 && k <= 5) ? 1'b0 : 1'b1;
      if (p < 6) drive(0, (p == 5) ? 4'd2 : 4'd1, 36'h50 + 36'(p), 1'b0);
      else       drive(0, 4'd0, 36'h0, 1'b0);
      @(negedge clk);
      acc = bus.in_ready[0] && (p < 6);
      if (bus.out_cycle_type != IDLE && bus.out_ready) got.push_back(out_beat());
      tick();
      if (acc) p++;
      if (!drop_seen && !bus.in_ready[0]) begin
        drop_seen      = 1'b1;
        pushes_at_drop = p;
      end
      if (k <= 5) chk($sformatf("t4_hold%0d", k), out_beat(), exp_beat(4'd1, 36'h50, 1'b0, 2'd0));
    end
    idle_all();
    chk("t4_drop_seen", 64'(drop_seen), 64'd1);
    chk("t4_pushes_at_drop", 64'(pushes_at_drop), 64'd4);
    chk("t4_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t4_got%0d", i), (i < got.size()) ? got[i] : 64'hFFFF_FFFF_FFFF_FFFF,
          exp_beat((i == 5) ? 4'd2 : 4'd1, 36'h50 + 36'(i), 1'b0, 2'd0));
    chk("t4_txn", 64'(bus.txn_count), 64'd7);

    // Illegal encoding on ch3 alongside a lone DONE on ch1
    drive(3, 4'hF, 36'h99, 1'b1); drive(1, 4'd2, 36'h61, 1'b1); tick();
    chk("t5_err", 64'(bus.err_illegal), 64'd1);
    chk("t5_d61", out_beat(), exp_beat(4'd2, 36'h61, 1'b1, 2'd1));
    chk("t5_ready", 64'(bus.in_ready), 64'hF);
    idle_all(); tick();
    chk("t5_idle", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd1));
    tick();
    chk("t5_no_ch3", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd1));
    chk("t5_err_sticky", 64'(bus.err_illegal), 64'd1);
    chk("t5_txn", 64'(bus.txn_count), 64'd8);

    // Reset while ch0 holds two buffered beats
    bus.out_ready = 1'b0;
    drive(0, 4'd1, 36'h70, 1'b0); tick();
    drive(0, 4'd1, 36'h71, 1'b0); tick();
    chk("t6_pre", out_beat(), exp_beat(4'd1, 36'h70, 1'b0, 2'd0));
    idle_all();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_out", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd0));
    chk("t6_ready", 64'(bus.in_ready), 64'hF);
    chk("t6_txn", 64'(bus.txn_count), 64'd0);
    chk("t6_err", 64'(bus.err_illegal), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("t6_flushed", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd0));
    drive(2, 4'd1, 36'h80, 1'b0); tick();
    chk("t6_v80", out_beat(), exp_beat(4'd1, 36'h80, 1'b0, 2'd2));
    drive(2, 4'd2, 36'h81, 1'b1); tick();
    chk("t6_d81", out_beat(), exp_beat(4'd2, 36'h81, 1'b1, 2'd2));
    idle_all(); tick();
    chk("t6_idle", out_beat(), exp_beat(4'd0, 36'h0, 1'b0, 2'd2));
    chk("t6_txn_after", 64'(bus.txn_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
